cache_bus_arbiter: RTL and testbench

//  Shares one cache-line memory bus between two cache masters: m0 = ICache, m1 = DCache.

---
 rtl/cache_bus_pkg.sv | 28 ++
 rtl/arb2_lock.sv | 63 ++++++
 rtl/cache_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_cache_bus_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_bus_pkg.sv
// cache_bus_pkg
//   Shared definitions for the two-master cache bus arbiter: default bus
//   widths, the per-channel arbiter state encoding, the arbitration policy
//   constants and the winner-selection helper used by arb2_lock.
package cache_bus_pkg;

    localparam int BUS_ADDR_W = 64;
    localparam int BUS_DATA_W = 64;

    localparam int POLICY_FIXED = 0;  // m1 (DCache) always wins a tie
    localparam int POLICY_RR    = 1;  // the loser of the last grant wins a tie

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } ch_state_t;

    // Winner among the requesters sampled in IDLE. A lone requester always
    // wins; a tie is broken by the policy.
    function automatic logic pick_owner(input logic [1:0] req,
                                        input logic       last_owner,
                                        input int         policy);
        if (req == 2'b11)
            return (policy == POLICY_FIXED) ? 1'b1 : ~last_owner;
        return req[1];
    endfunction

endpackage

// File: rtl/arb2_lock.sv
// arb2_lock
//   Two-way locking arbiter for one bus channel. A grant is taken in IDLE
//   when any request is high, registered (one cycle of latency) and held
//   until the release strobe, whatever the requests do meanwhile. At least
//   one IDLE cycle separates consecutive grants.
// Ports
//   clock       in   1  clock
//   reset       in   1  asynchronous, active-high
//   req[1:0]    in   2  request per master (bit 1 = DCache)
//   rel         in   1  end of the current transaction; only acted on in BUSY
//   grant[1:0]  out  2  one-hot owner, all zero while idle
//   busy        out  1  channel owned
//   last_owner  out  1  index of the most recent winner (1 after reset)
module arb2_lock
    import cache_bus_pkg::*;
#(
    parameter int POLICY = POLICY_RR
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       rel,
    output logic [1:0] grant,
    output logic       busy,
    output logic       last_owner
);

    ch_state_t state;
    logic      owner_q;
    logic      next_owner;

    assign next_owner = pick_owner(req, owner_q, POLICY);

    // NOTE: one always_ff with non-blocking assignments only; the winner is
    // computed combinationally above so no blocking temporaries are needed here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= CH_IDLE;
            owner_q <= 1'b1;
        end else begin
            case (state)
                CH_IDLE: begin
                    if (|req) begin
                        state   <= CH_BUSY;
                        owner_q <= next_owner;
                    end
                end
                CH_BUSY: begin
                    if (rel)
                        state <= CH_IDLE;
                end
                default: state <= CH_IDLE;
            endcase
        end
    end

    // The winner register doubles as the current owner while BUSY and as the
    // round-robin history while IDLE.
    assign busy       = (state == CH_BUSY);
    assign last_owner = owner_q;
    assign grant      = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter
//   Shares one cache-line memory bus between m0 (ICache) and m1 (DCache).
//   Read and write channels each have their own arb2_lock; a grant covers a
//   whole burst (read: until the rlast beat, write: until the b handshake).
//   Downstream signals are a combinational mux of the owner's signals, zero
//   when the channel is idle. Upstream strobes are gated to the owner; read
//   data is broadcast to both masters.
// Ports
//   clock, reset                     clock, asynchronous active-high reset
//   io_m{0,1}_r_*                    master read request / beat return
//   io_m{0,1}_w_*, io_m{0,1}_b_*     master write beats / write response
//   io_bus_r_*, io_bus_w_*, io_bus_b_*  downstream bus towards the AXI bridge
//   io_perf_r_wait, io_perf_w_wait   saturating wait-cycle counters
//                                    (present only with CACHE_ARB_PERF_EN)
// Configuration macro: CACHE_ARB_PERF_EN
module cache_bus_arbiter
    import cache_bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W,
    parameter int POLICY = POLICY_RR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_m0_r_valid,
    input  logic [ADDR_W-1:0] io_m0_r_raddr,
    output logic              io_m0_r_ready,
    output logic [DATA_W-1:0] io_m0_r_rdata,
    output logic              io_m0_r_rlast,
    input  logic              io_m0_w_valid,
    input  logic [ADDR_W-1:0] io_m0_w_waddr,
    input  logic [DATA_W-1:0] io_m0_w_wdata,
    input  logic              io_m0_w_wlast,
    output logic              io_m0_w_ready,
    input  logic              io_m0_b_ready,
    output logic              io_m0_b_valid,
    input  logic              io_m1_r_valid,
    input  logic [ADDR_W-1:0] io_m1_r_raddr,
    output logic              io_m1_r_ready,
    output logic [DATA_W-1:0] io_m1_r_rdata,
    output logic              io_m1_r_rlast,
    input  logic              io_m1_w_valid,
    input  logic [ADDR_W-1:0] io_m1_w_waddr,
    input  logic [DATA_W-1:0] io_m1_w_wdata,
    input  logic              io_m1_w_wlast,
    output logic              io_m1_w_ready,
    input  logic              io_m1_b_ready,
    output logic              io_m1_b_valid,
    output logic              io_bus_r_valid,
    output logic [ADDR_W-1:0] io_bus_r_raddr,
    input  logic              io_bus_r_ready,
    input  logic [DATA_W-1:0] io_bus_r_rdata,
    input  logic              io_bus_r_rlast,
    output logic              io_bus_w_valid,
    output logic [ADDR_W-1:0] io_bus_w_waddr,
    output logic [DATA_W-1:0] io_bus_w_wdata,
    output logic              io_bus_w_wlast,
    input  logic              io_bus_w_ready,
    input  logic              io_bus_b_valid,
    output logic              io_bus_b_ready
`ifdef CACHE_ARB_PERF_EN
    ,
    output logic [31:0]       io_perf_r_wait,
    output logic [31:0]       io_perf_w_wait
`endif
);

    logic [1:0] r_grant, w_grant;
    logic       r_busy, w_busy;
    logic       r_sel, w_sel;

    arb2_lock #(.POLICY(POLICY)) u_r_arb (
        .clock      (clock),
        .reset      (reset),
        .req        ({io_m1_r_valid, io_m0_r_valid}),
        .rel        (io_bus_r_ready & io_bus_r_rlast),
        .grant      (r_grant),
        .busy       (r_busy),
        .last_owner (r_sel)
    );

    // Writes end on the response handshake, not on wlast, so the owner also
    // collects its b beat before the other master can start.
    arb2_lock #(.POLICY(POLICY)) u_w_arb (
        .clock      (clock),
        .reset      (reset),
        .req        ({io_m1_w_valid, io_m0_w_valid}),
        .rel        (io_bus_b_valid & io_bus_b_ready),
        .grant      (w_grant),
        .busy       (w_busy),
        .last_owner (w_sel)
    );

    // Read channel
    assign io_bus_r_valid = r_busy & (r_sel ? io_m1_r_valid : io_m0_r_valid);
    assign io_bus_r_raddr = r_busy ? (r_sel ? io_m1_r_raddr : io_m0_r_raddr) : '0;
    assign io_m0_r_ready  = r_grant[0] & io_bus_r_ready;
    assign io_m1_r_ready  = r_grant[1] & io_bus_r_ready;
    assign io_m0_r_rlast  = r_grant[0] & io_bus_r_rlast;
    assign io_m1_r_rlast  = r_grant[1] & io_bus_r_rlast;
    assign io_m0_r_rdata  = io_bus_r_rdata;
    assign io_m1_r_rdata  = io_bus_r_rdata;

    // Write channel
    assign io_bus_w_valid = w_busy & (w_sel ? io_m1_w_valid : io_m0_w_valid);
    assign io_bus_w_waddr = w_busy ? (w_sel ? io_m1_w_waddr : io_m0_w_waddr) : '0;
    assign io_bus_w_wdata = w_busy ? (w_sel ? io_m1_w_wdata : io_m0_w_wdata) : '0;
    assign io_bus_w_wlast = w_busy & (w_sel ? io_m1_w_wlast : io_m0_w_wlast);
    assign io_bus_b_ready = w_busy & (w_sel ? io_m1_b_ready : io_m0_b_ready);
    assign io_m0_w_ready  = w_grant[0] & io_bus_w_ready;
    assign io_m1_w_ready  = w_grant[1] & io_bus_w_ready;
    assign io_m0_b_valid  = w_grant[0] & io_bus_b_valid;
    assign io_m1_b_valid  = w_grant[1] & io_bus_b_valid;

`ifdef CACHE_ARB_PERF_EN
    // A wait cycle is one where the channel is owned and the other master
    // is holding its request.
    logic r_wait_evt, w_wait_evt;

    assign r_wait_evt = r_busy & (r_sel ? io_m0_r_valid : io_m1_r_valid);
    assign w_wait_evt = w_busy & (w_sel ? io_m0_w_valid : io_m1_w_valid);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_perf_r_wait <= '0;
            io_perf_w_wait <= '0;
        end else begin
            if (r_wait_evt && io_perf_r_wait != 32'hFFFF_FFFF)
                io_perf_r_wait <= io_perf_r_wait + 32'd1;
            if (w_wait_evt && io_perf_w_wait != 32'hFFFF_FFFF)
                io_perf_w_wait <= io_perf_w_wait + 32'd1;
        end
    end
`else
    // Without the performance option there are no counters and no extra ports.
`endif

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb_cache_bus_arbiter
//   Directed bench for cache_bus_arbiter. The main instance uses round-robin
//   arbitration; a second fixed-priority instance shares all inputs and is
//   observed only on its downstream read address for tie-break checks.
module tb_cache_bus_arbiter;
    import cache_bus_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    always #5 clock = ~clock;

    logic          io_m0_r_valid, io_m1_r_valid;
    logic [AW-1:0] io_m0_r_raddr, io_m1_r_raddr;
    logic          io_m0_w_valid, io_m1_w_valid;
    logic [AW-1:0] io_m0_w_waddr, io_m1_w_waddr;
    logic [DW-1:0] io_m0_w_wdata, io_m1_w_wdata;
    logic          io_m0_w_wlast, io_m1_w_wlast;
    logic          io_m0_b_ready, io_m1_b_ready;
    logic          io_bus_r_ready, io_bus_r_rlast;
    logic [DW-1:0] io_bus_r_rdata;
    logic          io_bus_w_ready, io_bus_b_valid;

    logic          io_m0_r_ready, io_m1_r_ready, io_m0_r_rlast, io_m1_r_rlast;
    logic [DW-1:0] io_m0_r_rdata, io_m1_r_rdata;
    logic          io_m0_w_ready, io_m1_w_ready, io_m0_b_valid, io_m1_b_valid;
    logic          io_bus_r_valid, io_bus_w_valid, io_bus_w_wlast, io_bus_b_ready;
    logic [AW-1:0] io_bus_r_raddr, io_bus_w_waddr;
    logic [DW-1:0] io_bus_w_wdata;

    logic          f_m0_r_ready, f_m1_r_ready, f_m0_r_rlast, f_m1_r_rlast;
    logic [DW-1:0] f_m0_r_rdata, f_m1_r_rdata;
    logic          f_m0_w_ready, f_m1_w_ready, f_m0_b_valid, f_m1_b_valid;
    logic          f_bus_r_valid, f_bus_w_valid, f_bus_w_wlast, f_bus_b_ready;
    logic [AW-1:0] f_bus_r_raddr, f_bus_w_waddr;
    logic [DW-1:0] f_bus_w_wdata;
`ifdef CACHE_ARB_PERF_EN
    logic [31:0]   io_perf_r_wait, io_perf_w_wait, f_perf_r_wait, f_perf_w_wait;
`endif

    cache_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .POLICY(POLICY_RR)) dut (
        .clock(clock), .reset(reset),
        .io_m0_r_valid(io_m0_r_valid), .io_m0_r_raddr(io_m0_r_raddr),
        .io_m0_r_ready(io_m0_r_ready), .io_m0_r_rdata(io_m0_r_rdata), .io_m0_r_rlast(io_m0_r_rlast),
        .io_m0_w_valid(io_m0_w_valid), .io_m0_w_waddr(io_m0_w_waddr), .io_m0_w_wdata(io_m0_w_wdata),
        .io_m0_w_wlast(io_m0_w_wlast), .io_m0_w_ready(io_m0_w_ready),
        .io_m0_b_ready(io_m0_b_ready), .io_m0_b_valid(io_m0_b_valid),
        .io_m1_r_valid(io_m1_r_valid), .io_m1_r_raddr(io_m1_r_raddr),
        .io_m1_r_ready(io_m1_r_ready), .io_m1_r_rdata(io_m1_r_rdata), .io_m1_r_rlast(io_m1_r_rlast),
        .io_m1_w_valid(io_m1_w_valid), .io_m1_w_waddr(io_m1_w_waddr), .io_m1_w_wdata(io_m1_w_wdata),
        .io_m1_w_wlast(io_m1_w_wlast), .io_m1_w_ready(io_m1_w_ready),
        .io_m1_b_ready(io_m1_b_ready), .io_m1_b_valid(io_m1_b_valid),
        .io_bus_r_valid(io_bus_r_valid), .io_bus_r_raddr(io_bus_r_raddr),
        .io_bus_r_ready(io_bus_r_ready), .io_bus_r_rdata(io_bus_r_rdata), .io_bus_r_rlast(io_bus_r_rlast),
        .io_bus_w_valid(io_bus_w_valid), .io_bus_w_waddr(io_bus_w_waddr), .io_bus_w_wdata(io_bus_w_wdata),
        .io_bus_w_wlast(io_bus_w_wlast), .io_bus_w_ready(io_bus_w_ready),
        .io_bus_b_valid(io_bus_b_valid), .io_bus_b_ready(io_bus_b_ready)
`ifdef CACHE_ARB_PERF_EN
        , .io_perf_r_wait(io_perf_r_wait), .io_perf_w_wait(io_perf_w_wait)
`endif
    );

    cache_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .POLICY(POLICY_FIXED)) dut_fixed (
        .clock(clock), .reset(reset),
        .io_m0_r_valid(io_m0_r_valid), .io_m0_r_raddr(io_m0_r_raddr),
        .io_m0_r_ready(f_m0_r_ready), .io_m0_r_rdata(f_m0_r_rdata), .io_m0_r_rlast(f_m0_r_rlast),
        .io_m0_w_valid(io_m0_w_valid), .io_m0_w_waddr(io_m0_w_waddr), .io_m0_w_wdata(io_m0_w_wdata),
        .io_m0_w_wlast(io_m0_w_wlast), .io_m0_w_ready(f_m0_w_ready),
        .io_m0_b_ready(io_m0_b_ready), .io_m0_b_valid(f_m0_b_valid),
        .io_m1_r_valid(io_m1_r_valid), .io_m1_r_raddr(io_m1_r_raddr),
        .io_m1_r_ready(f_m1_r_ready), .io_m1_r_rdata(f_m1_r_rdata), .io_m1_r_rlast(f_m1_r_rlast),
        .io_m1_w_valid(io_m1_w_valid), .io_m1_w_waddr(io_m1_w_waddr), .io_m1_w_wdata(io_m1_w_wdata),
        .io_m1_w_wlast(io_m1_w_wlast), .io_m1_w_ready(f_m1_w_ready),
        .io_m1_b_ready(io_m1_b_ready), .io_m1_b_valid(f_m1_b_valid),
        .io_bus_r_valid(f_bus_r_valid), .io_bus_r_raddr(f_bus_r_raddr),
        .io_bus_r_ready(io_bus_r_ready), .io_bus_r_rdata(io_bus_r_rdata), .io_bus_r_rlast(io_bus_r_rlast),
        .io_bus_w_valid(f_bus_w_valid), .io_bus_w_waddr(f_bus_w_waddr), .io_bus_w_wdata(f_bus_w_wdata),
        .io_bus_w_wlast(f_bus_w_wlast), .io_bus_w_ready(io_bus_w_ready),
        .io_bus_b_valid(io_bus_b_valid), .io_bus_b_ready(f_bus_b_ready)
`ifdef CACHE_ARB_PERF_EN
        , .io_perf_r_wait(f_perf_r_wait), .io_perf_w_wait(f_perf_w_wait)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge; outputs are checked 1 later.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        io_m0_r_valid = 0; io_m0_r_raddr = '0; io_m1_r_valid = 0; io_m1_r_raddr = '0;
        io_m0_w_valid = 0; io_m0_w_waddr = '0; io_m0_w_wdata = '0; io_m0_w_wlast = 0;
        io_m1_w_valid = 0; io_m1_w_waddr = '0; io_m1_w_wdata = '0; io_m1_w_wlast = 0;
        io_m0_b_ready = 0; io_m1_b_ready = 0;
        io_bus_r_ready = 0; io_bus_r_rdata = '0; io_bus_r_rlast = 0;
        io_bus_w_ready = 0; io_bus_b_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        settle();
        reset = 0;
        settle();
    endtask

    // Two-beat read return to the current owner; ends just after the rlast edge.
    task automatic r_beats(input logic owner, input logic [63:0] d0, input logic [63:0] d1);
        io_bus_r_ready = 1; io_bus_r_rdata = d0; io_bus_r_rlast = 0;
        settle();
        check("beat0_ready_owner", owner ? io_m1_r_ready : io_m0_r_ready, 64'd1);
        check("beat0_ready_other", owner ? io_m0_r_ready : io_m1_r_ready, 64'd0);
        check("beat0_rdata",       owner ? io_m1_r_rdata : io_m0_r_rdata, d0);
        check("beat0_rlast",       owner ? io_m1_r_rlast : io_m0_r_rlast, 64'd0);
        tick();
        io_bus_r_rdata = d1; io_bus_r_rlast = 1;
        settle();
        check("beat1_rlast_owner", owner ? io_m1_r_rlast : io_m0_r_rlast, 64'd1);
        check("beat1_rlast_other", owner ? io_m0_r_rlast : io_m1_r_rlast, 64'd0);
        check("beat1_rdata",       owner ? io_m1_r_rdata : io_m0_r_rdata, d1);
        tick();
        io_bus_r_ready = 0; io_bus_r_rlast = 0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        // Reset holds everything idle even with requests and bus activity.
        io_m0_r_valid = 1; io_m0_r_raddr = 64'h8000_0010; io_bus_r_ready = 1;
        io_m1_w_valid = 1; io_m1_b_ready = 1;
        tick(); tick(); settle();
        check("rst_bus_r_valid", io_bus_r_valid, 64'd0);
        check("rst_bus_r_raddr", io_bus_r_raddr, 64'd0);
        check("rst_bus_w_valid", io_bus_w_valid, 64'd0);
        check("rst_bus_b_ready", io_bus_b_ready, 64'd0);
        check("rst_m0_r_ready",  io_m0_r_ready,  64'd0);
        clear_inputs();
        reset = 0;

        // 1: single m0 read, two beats.
        tick();
        io_m0_r_valid = 1; io_m0_r_raddr = 64'h8000_0010;
        settle();
        check("t1_no_same_cycle_grant", io_bus_r_valid, 64'd0);
        tick(); settle();
        check("t1_bus_r_valid", io_bus_r_valid, 64'd1);
        check("t1_bus_r_raddr", io_bus_r_raddr, 64'h8000_0010);
        check("t1_w_idle",      io_bus_w_valid, 64'd0);
        r_beats(1'b0, 64'h1111, 64'h2222);
        io_m0_r_valid = 0;
        io_bus_r_ready = 1;
        settle();
        check("t1_idle_valid", io_bus_r_valid, 64'd0);
        check("t1_idle_raddr", io_bus_r_raddr, 64'd0);
        check("t1_idle_gate",  io_m0_r_ready,  64'd0);
        io_bus_r_ready = 0;

        // 2: simultaneous reads; round-robin serves m0 first after reset,
        //    fixed priority serves m1.
        do_reset();
        io_m0_r_valid = 1; io_m0_r_raddr = 64'h8000_0100;
        io_m1_r_valid = 1; io_m1_r_raddr = 64'h8000_0200;
        tick(); settle();
        check("t2_rr_first",    io_bus_r_raddr, 64'h8000_0100);
        check("t2_fixed_first", f_bus_r_raddr,  64'h8000_0200);
        r_beats(1'b0, 64'h2000, 64'h2001);
        io_m0_r_valid = 0;
        settle();
        check("t2_release_idle", io_bus_r_valid, 64'd0);
        io_m0_r_valid = 1;
        tick(); settle();
        check("t2_rr_second",    io_bus_r_raddr, 64'h8000_0200);
        check("t2_fixed_second", f_bus_r_raddr,  64'h8000_0200);
        r_beats(1'b1, 64'h2010, 64'h2011);
        settle();
        check("t2_release_idle2", io_bus_r_valid, 64'd0);
        tick(); settle();
        check("t2_rr_third",    io_bus_r_raddr, 64'h8000_0100);
        check("t2_fixed_third", f_bus_r_raddr,  64'h8000_0200);
        r_beats(1'b0, 64'h2020, 64'h2021);
        io_m0_r_valid = 0; io_m1_r_valid = 0;

        // 3: m1 write-back concurrent with an m0 read.
        do_reset();
        io_m0_r_valid = 1; io_m0_r_raddr = 64'h8000_0300;
        io_m1_w_valid = 1; io_m1_w_waddr = 64'h8000_1000;
        io_m1_w_wdata = 64'hAAAA; io_m1_w_wlast = 0;
        tick(); settle();
        check("t3_r_busy",     io_bus_r_valid, 64'd1);
        check("t3_w_valid",    io_bus_w_valid, 64'd1);
        check("t3_w_waddr",    io_bus_w_waddr, 64'h8000_1000);
        check("t3_w_wdata0",   io_bus_w_wdata, 64'hAAAA);
        io_bus_w_ready = 1;
        settle();
        check("t3_m1_w_ready", io_m1_w_ready, 64'd1);
        check("t3_m0_w_ready", io_m0_w_ready, 64'd0);
        tick();
        io_m1_w_wdata = 64'hBBBB; io_m1_w_wlast = 1;
        settle();
        check("t3_w_wlast",    io_bus_w_wlast, 64'd1);
        check("t3_w_wdata1",   io_bus_w_wdata, 64'hBBBB);
        tick();
        io_m1_w_valid = 0; io_m1_w_wlast = 0; io_bus_w_ready = 0; io_m1_b_ready = 1;
        settle();
        check("t3_held_after_wlast", io_bus_b_ready, 64'd1);
        check("t3_w_valid_dropped",  io_bus_w_valid, 64'd0);
        io_bus_b_valid = 1;
        settle();
        check("t3_m1_b_valid", io_m1_b_valid, 64'd1);
        check("t3_m0_b_valid", io_m0_b_valid, 64'd0);
        check("t3_r_still",    io_bus_r_valid, 64'd1);
        tick();
        io_bus_b_valid = 0;
        settle();
        check("t3_w_released", io_bus_b_ready, 64'd0);
        io_m1_b_ready = 0;
        r_beats(1'b0, 64'h3000, 64'h3001);
        io_m0_r_valid = 0;

        // 4: m1 request arriving mid m0 burst waits for rlast plus one idle cycle.
        io_m0_r_valid = 1; io_m0_r_raddr = 64'h8000_0400;
        tick();
        io_bus_r_ready = 1; io_bus_r_rdata = 64'h4440; io_bus_r_rlast = 0;
        io_m1_r_valid = 1; io_m1_r_raddr = 64'h8000_0500;
        settle();
        check("t4_keep_owner0", io_bus_r_raddr, 64'h8000_0400);
        check("t4_m1_ready",    io_m1_r_ready,  64'd0);
        tick();
        io_bus_r_rdata = 64'h4441; io_bus_r_rlast = 1;
        io_m0_r_valid = 0;
        settle();
        check("t4_early_drop_keeps", io_m0_r_rlast,  64'd1);
        check("t4_keep_owner1",      io_bus_r_raddr, 64'h8000_0400);
        tick();
        io_bus_r_ready = 0; io_bus_r_rlast = 0;
        settle();
        check("t4_idle_gap", io_bus_r_valid, 64'd0);
        tick(); settle();
        check("t4_m1_valid", io_bus_r_valid, 64'd1);
        check("t4_m1_raddr", io_bus_r_raddr, 64'h8000_0500);
        r_beats(1'b1, 64'h4500, 64'h4501);
        io_m1_r_valid = 0;

        // 5: async reset during beat 1 of a read with a write also active.
        io_m0_r_valid = 1; io_m0_r_raddr = 64'h8000_0600;
        io_m1_w_valid = 1; io_m1_w_waddr = 64'h8000_1100; io_m1_w_wdata = 64'hCCCC;
        io_m1_b_ready = 1;
        tick();
        io_bus_r_ready = 1; io_bus_r_rdata = 64'h5550;
        settle();
        check("t5_pre_r_valid", io_bus_r_valid, 64'd1);
        check("t5_pre_w_valid", io_bus_w_valid, 64'd1);
        check("t5_pre_b_ready", io_bus_b_ready, 64'd1);
        #1;
        reset = 1;
        #1;
        check("t5_rst_r_valid", io_bus_r_valid, 64'd0);
        check("t5_rst_w_valid", io_bus_w_valid, 64'd0);
        check("t5_rst_b_ready", io_bus_b_ready, 64'd0);
        check("t5_rst_m0_ready", io_m0_r_ready, 64'd0);
        check("t5_rst_raddr",   io_bus_r_raddr, 64'd0);
        clear_inputs();
        reset = 0;
        tick(); settle();
        check("t5_post_idle", io_bus_r_valid, 64'd0);
        io_m0_r_valid = 1; io_m0_r_raddr = 64'h8000_0700;
        io_m1_r_valid = 1; io_m1_r_raddr = 64'h8000_0800;
        tick(); settle();
        check("t5_regrant_rr", io_bus_r_raddr, 64'h8000_0700);
        r_beats(1'b0, 64'h5700, 64'h5701);
        io_m0_r_valid = 0; io_m1_r_valid = 0;

`ifdef CACHE_ARB_PERF_EN
        // 6: m1 holds its read for five owned cycles behind m0.
        do_reset();
        io_m0_r_valid = 1; io_m0_r_raddr = 64'h8000_0900;
        tick();
        io_m1_r_valid = 1; io_m1_r_raddr = 64'h8000_0A00;
        tick(); tick(); tick();
        r_beats(1'b0, 64'h6000, 64'h6001);
        io_m0_r_valid = 0;
        settle();
        check("t6_perf_r_wait", io_perf_r_wait, 64'd5);
        check("t6_perf_w_wait", io_perf_w_wait, 64'd0);
        io_m1_r_valid = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
